// File: rtl/horner_pkg.sv
// Shared definitions for the Horner-loop sequencer: FSM encoding, SMC zero and
// counter sizing.
package horner_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_WAIT,
    S_UPDATE,
    S_CONVERT
  } state_t;

  localparam logic [31:0] SMC_ZERO = 32'h0000_0000;

  // Bits needed for a down-counter that must hold values 0..n-1.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/horner_coef_bank.sv
// Per-channel coefficient register file: one write port, combinational read.
// Out-of-range read indices return SMC zero.
module horner_coef_bank
  import horner_pkg::*;
#(
  parameter int ORDER = 10,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [31:0]      wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data
);

  logic [31:0] mem [ORDER+1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= ORDER; i++) mem[i] <= SMC_ZERO;
    end else if (wr_en && (int'(wr_addr) <= ORDER)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = (int'(rd_idx) <= ORDER) ? mem[rd_idx] : SMC_ZERO;

endmodule

// File: rtl/horner_seq.sv
// Sequencer for one NLC channel's Horner loop: latch sample, clear the sum,
// run ORDER+1 multiply-add iterations, then capture the fixed-point result.
module horner_seq
  import horner_pkg::*;
#(
  parameter int ORDER    = 10,
  parameter int MULT_LAT = 2,
  parameter int ADD_LAT  = 3,
  parameter int CONV_LAT = 2
) (
  input  logic        clk,
  input  logic        GlobalReset,
  input  logic        sample_vld,
  input  logic [31:0] sample_smc,
  input  logic        coef_wr_en,
  input  logic [3:0]  coef_wr_addr,
  input  logic [31:0] coef_wr_data,
  input  logic [20:0] x_lin_i,
  output logic [31:0] x_adc_smc,
  output logic        srdyi_o,
  output logic [31:0] coeff,
  output logic        sum_en,
  output logic        sum_rst,
  output logic [20:0] x_lin,
  output logic        x_lin_vld,
  output logic        busy,
  output logic        overrun,
  output logic        coef_wr_err
);

  localparam int L     = MULT_LAT + ADD_LAT;
  localparam int CNT_N = (L > CONV_LAT + 1) ? L : CONV_LAT + 1;
  localparam int CNT_W = cnt_width(CNT_N);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(L - 2);
  localparam logic [CNT_W-1:0] CONV_INIT = CNT_W'(CONV_LAT);
  localparam logic [3:0]       K_TOP     = 4'(ORDER);

  state_t           state, state_nxt;
  logic [3:0]       k;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       rd_idx;
  logic [31:0]      rd_data;
  logic             accept;
  logic             wr_ok;
  logic             capture;

  assign busy   = (state != S_IDLE);
  assign accept = (state == S_IDLE) && sample_vld;
  assign wr_ok  = coef_wr_en && !busy && (coef_wr_addr <= K_TOP);

  horner_coef_bank #(
    .ORDER (ORDER),
    .IDX_W (4)
  ) u_bank (
    .clk     (clk),
    .rst     (GlobalReset),
    .wr_en   (wr_ok),
    .wr_addr (coef_wr_addr),
    .wr_data (coef_wr_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) state <= S_IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sum_rst   = 1'b0;
    srdyi_o   = 1'b0;
    sum_en    = 1'b0;
    capture   = 1'b0;
    // In UPDATE the next coefficient is k-1, loaded on the edge into ISSUE.
    rd_idx    = k;
    case (state)
      S_IDLE:    if (sample_vld) state_nxt = S_CLEAR;
      S_CLEAR: begin
        sum_rst   = 1'b1;
        state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        srdyi_o   = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT:    if (cnt == '0) state_nxt = S_UPDATE;
      S_UPDATE: begin
        sum_en    = 1'b1;
        rd_idx    = k - 4'd1;
        state_nxt = (k == 4'd0) ? S_CONVERT : S_ISSUE;
      end
      S_CONVERT: begin
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      k           <= 4'd0;
      cnt         <= '0;
      x_adc_smc   <= SMC_ZERO;
      coeff       <= SMC_ZERO;
      x_lin       <= 21'd0;
      x_lin_vld   <= 1'b0;
      overrun     <= 1'b0;
      coef_wr_err <= 1'b0;
    end else begin
      x_lin_vld   <= capture;
      overrun     <= sample_vld && busy;
      coef_wr_err <= coef_wr_en && !wr_ok;
      if (accept) begin
        x_adc_smc <= sample_smc;
        k         <= K_TOP;
      end
      if (state_nxt == S_ISSUE) coeff <= rd_data;
      if (state == S_UPDATE && k != 4'd0) k <= k - 4'd1;
      // One counter serves both the iteration wait and the converter wait.
      if (state == S_ISSUE)       cnt <= WAIT_INIT;
      else if (state == S_UPDATE) cnt <= CONV_INIT;
      else if (cnt != '0)         cnt <= cnt - 1'b1;
      if (capture) x_lin <= x_lin_i;
    end
  end

endmodule

// File: tb/tb_horner_seq.sv
// Scoreboard bench for horner_seq: the stimulus side predicts every output
// pulse from the cycle timeline, a negedge monitor consumes the predictions.
module tb_horner_seq;

  localparam int ORDER    = 10;
  localparam int MULT_LAT = 2;
  localparam int ADD_LAT  = 3;
  localparam int CONV_LAT = 2;
  localparam int L        = MULT_LAT + ADD_LAT;
  localparam int P        = L + 1;
  localparam int LAST_SUM = 2 + ORDER * P + L;
  localparam int CAP      = LAST_SUM + CONV_LAT + 1;
  localparam int VLD      = CAP + 1;
  localparam int TAB_N    = 4096;

  localparam logic [31:0] F_ONE  = 32'h3F80_0000;
  localparam logic [31:0] F_TWO  = 32'h4000_0000;
  localparam logic [31:0] F_HALF = 32'h3F00_0000;

  logic        clk = 1'b0;
  logic        GlobalReset;
  logic        sample_vld;
  logic [31:0] sample_smc;
  logic        coef_wr_en;
  logic [3:0]  coef_wr_addr;
  logic [31:0] coef_wr_data;
  logic [20:0] x_lin_i;
  logic [31:0] x_adc_smc;
  logic        srdyi_o;
  logic [31:0] coeff;
  logic        sum_en;
  logic        sum_rst;
  logic [20:0] x_lin;
  logic        x_lin_vld;
  logic        busy;
  logic        overrun;
  logic        coef_wr_err;

  horner_seq #(
    .ORDER(ORDER), .MULT_LAT(MULT_LAT), .ADD_LAT(ADD_LAT), .CONV_LAT(CONV_LAT)
  ) dut (
    .clk(clk), .GlobalReset(GlobalReset), .sample_vld(sample_vld),
    .sample_smc(sample_smc), .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr),
    .coef_wr_data(coef_wr_data), .x_lin_i(x_lin_i), .x_adc_smc(x_adc_smc),
    .srdyi_o(srdyi_o), .coeff(coeff), .sum_en(sum_en), .sum_rst(sum_rst),
    .x_lin(x_lin), .x_lin_vld(x_lin_vld), .busy(busy), .overrun(overrun),
    .coef_wr_err(coef_wr_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic [31:0] b;
  } ev_t;

  ev_t q_rst[$], q_srdy[$], q_sen[$], q_vld[$], q_ovr[$], q_err[$];

  logic [20:0] xl_tab [TAB_N];
  logic [31:0] bank_m [ORDER+1];
  int acc_cyc = -1000;
  int free_at = 0;
  int n_chk = 0;
  int n_fail = 0;
  bit started = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic bit model_busy(input int c);
    return (c > acc_cyc) && (c < free_at);
  endfunction

  // Reference model: applies one cycle of inputs and predicts future pulses.
  task automatic model_cycle(input bit sv, input logic [31:0] smp, input bit we,
                             input logic [3:0] wa, input logic [31:0] wd);
    bit  bz;
    ev_t e;
    bz = model_busy(cyc);
    if (we) begin
      if (!bz && wa <= ORDER) bank_m[wa] = wd;
      else begin e = '{cyc + 1, 32'h0, 32'h0}; q_err.push_back(e); end
    end
    if (sv) begin
      if (bz) begin
        e = '{cyc + 1, 32'h0, 32'h0}; q_ovr.push_back(e);
      end else begin
        acc_cyc = cyc;
        free_at = cyc + VLD;
        e = '{cyc + 1, 32'h0, 32'h0}; q_rst.push_back(e);
        for (int j = 0; j <= ORDER; j++) begin
          e = '{cyc + 2 + j * P, bank_m[ORDER - j], smp}; q_srdy.push_back(e);
          e = '{cyc + 2 + j * P + L, 32'h0, 32'h0};       q_sen.push_back(e);
        end
        e = '{cyc + VLD, {11'b0, xl_tab[(cyc + CAP) % TAB_N]}, 32'h0};
        q_vld.push_back(e);
      end
    end
  endtask

  task automatic drive(input bit sv, input logic [31:0] smp, input bit we,
                       input logic [3:0] wa, input logic [31:0] wd);
    sample_vld   = sv;
    sample_smc   = smp;
    coef_wr_en   = we;
    coef_wr_addr = wa;
    coef_wr_data = wd;
    x_lin_i      = xl_tab[cyc % TAB_N];
    model_cycle(sv, smp, we, wa, wd);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 32'h0, 1'b0, 4'd0, 32'h0);
  endtask

  task automatic do_reset();
    GlobalReset = 1'b1;
    sample_vld  = 1'b0;
    coef_wr_en  = 1'b0;
    #1;
    chk("rst_x_adc_smc", x_adc_smc, 32'h0);
    chk("rst_coeff", coeff, 32'h0);
    chk("rst_srdyi_o", {31'b0, srdyi_o}, 32'h0);
    chk("rst_sum_en", {31'b0, sum_en}, 32'h0);
    chk("rst_sum_rst", {31'b0, sum_rst}, 32'h0);
    chk("rst_x_lin", {11'b0, x_lin}, 32'h0);
    chk("rst_x_lin_vld", {31'b0, x_lin_vld}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_overrun", {31'b0, overrun}, 32'h0);
    chk("rst_coef_wr_err", {31'b0, coef_wr_err}, 32'h0);
    q_rst.delete(); q_srdy.delete(); q_sen.delete();
    q_vld.delete(); q_ovr.delete(); q_err.delete();
    for (int i = 0; i <= ORDER; i++) bank_m[i] = 32'h0;
    acc_cyc = -1000;
    free_at = 0;
    repeat (2) @(posedge clk);
    #1;
    GlobalReset = 1'b0;
    started     = 1'b1;
  endtask

  always @(negedge clk) begin : monitor
    ev_t e;
    if (started && !GlobalReset) begin
      if (sum_rst) begin
        if (q_rst.size() == 0) chk("sum_rst_unexpected", 32'h1, 32'h0);
        else begin e = q_rst.pop_front(); chk("sum_rst_cycle", cyc, e.cyc); end
      end
      if (srdyi_o) begin
        if (q_srdy.size() == 0) chk("srdyi_unexpected", 32'h1, 32'h0);
        else begin
          e = q_srdy.pop_front();
          chk("srdyi_cycle", cyc, e.cyc);
          chk("coeff", coeff, e.a);
          chk("x_adc_smc", x_adc_smc, e.b);
        end
      end
      if (sum_en) begin
        if (q_sen.size() == 0) chk("sum_en_unexpected", 32'h1, 32'h0);
        else begin e = q_sen.pop_front(); chk("sum_en_cycle", cyc, e.cyc); end
      end
      if (x_lin_vld) begin
        if (q_vld.size() == 0) chk("x_lin_vld_unexpected", 32'h1, 32'h0);
        else begin
          e = q_vld.pop_front();
          chk("x_lin_vld_cycle", cyc, e.cyc);
          chk("x_lin", {11'b0, x_lin}, e.a);
        end
      end
      if (overrun) begin
        if (q_ovr.size() == 0) chk("overrun_unexpected", 32'h1, 32'h0);
        else begin e = q_ovr.pop_front(); chk("overrun_cycle", cyc, e.cyc); end
      end
      if (coef_wr_err) begin
        if (q_err.size() == 0) chk("coef_wr_err_unexpected", 32'h1, 32'h0);
        else begin e = q_err.pop_front(); chk("coef_wr_err_cycle", cyc, e.cyc); end
      end
      chk("busy", {31'b0, busy}, {31'b0, model_busy(cyc)});
      chk("sum_rst_sum_en_excl", {31'b0, sum_rst & sum_en}, 32'h0);
    end
  end

  initial begin
    #(100000 * 10);
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "simulation time limit");
  end

  initial begin
    for (int i = 0; i < TAB_N; i++) xl_tab[i] = 21'($urandom);
    GlobalReset  = 1'b0;
    sample_vld   = 1'b0;
    sample_smc   = 32'h0;
    coef_wr_en   = 1'b0;
    coef_wr_addr = 4'd0;
    coef_wr_data = 32'h0;
    x_lin_i      = 21'd0;
    @(posedge clk);
    #1;
    do_reset();

    // c0 = 1.0, everything else 0, x = 2.0
    drive(1'b0, 32'h0, 1'b1, 4'd0, F_ONE);
    for (int a = 1; a <= ORDER; a++) drive(1'b0, 32'h0, 1'b1, 4'(a), 32'h0);
    drive(1'b1, F_TWO, 1'b0, 4'd0, 32'h0);
    idle(VLD + 4);

    // c1 = 1.0 only, x = 0.5
    drive(1'b0, 32'h0, 1'b1, 4'd1, F_ONE);
    drive(1'b0, 32'h0, 1'b1, 4'd0, 32'h0);
    drive(1'b1, F_HALF, 1'b0, 4'd0, 32'h0);
    idle(VLD + 4);

    // second sample 30 cycles into a conversion is dropped
    drive(1'b1, F_TWO, 1'b0, 4'd0, 32'h0);
    idle(29);
    drive(1'b1, F_HALF, 1'b0, 4'd0, 32'h0);
    idle(VLD - 30 + 4);

    // out-of-range write, and write while busy, are both rejected
    drive(1'b0, 32'h0, 1'b1, 4'd3, 32'h1234_5678);
    drive(1'b0, 32'h0, 1'b1, 4'd11, F_ONE);
    drive(1'b1, F_TWO, 1'b0, 4'd0, 32'h0);
    idle(9);
    drive(1'b0, 32'h0, 1'b1, 4'd3, 32'hDEAD_BEEF);
    idle(VLD);
    drive(1'b1, F_ONE, 1'b0, 4'd0, 32'h0);
    idle(VLD + 4);

    // reset in cycle 40 of a conversion, then a clean run
    drive(1'b1, F_TWO, 1'b0, 4'd0, 32'h0);
    idle(39);
    do_reset();
    drive(1'b0, 32'h0, 1'b1, 4'd0, F_ONE);
    drive(1'b1, F_HALF, 1'b0, 4'd0, 32'h0);
    idle(VLD + 4);

    // back-to-back: next sample in the x_lin_vld cycle, with a same-cycle write
    drive(1'b1, F_TWO, 1'b0, 4'd0, 32'h0);
    idle(VLD - 1);
    drive(1'b1, F_HALF, 1'b1, 4'd10, 32'hCAFE_0000);
    idle(VLD + 4);

    // random traffic
    repeat (800) begin
      drive($urandom_range(0, 24) == 0, $urandom, $urandom_range(0, 7) == 0,
            4'($urandom_range(0, 15)), $urandom);
    end
    idle(VLD + 4);

    chk("pending_sum_rst", q_rst.size(), 32'h0);
    chk("pending_srdyi", q_srdy.size(), 32'h0);
    chk("pending_sum_en", q_sen.size(), 32'h0);
    chk("pending_x_lin_vld", q_vld.size(), 32'h0);
    chk("pending_overrun", q_ovr.size(), 32'h0);
    chk("pending_coef_wr_err", q_err.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
